// File: rtl/dvi_stream_sync.sv
// DVI raster generator that locks a valid/ready pixel stream (SOF/EOL marked) to the timing.
// Optional build macro DVI_STREAM_SYNC_PATTERN_EN: colour bars replace black while unlocked.
module dvi_stream_sync #(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_sof_i,
  input  logic               s_eol_i,
  input  logic [COLOR_W-1:0] s_red_i,
  input  logic [COLOR_W-1:0] s_green_i,
  input  logic [COLOR_W-1:0] s_blue_i,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic [HW-1:0]      x_o,
  output logic [VW-1:0]      y_o,
  output logic               locked_o,
  output logic               frame_start_o,
  output logic               err_o
);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  typedef enum logic {SEEK, LOCKED} state_t;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active, at_org, line_end, in_hs, in_vs;
  logic          ready, err;
  state_t        state, state_d;
  pix_t          beat, pix_d, pix_q, seek_pix;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Compare in int so sync windows ending exactly at the total do not overflow.
  assign active   = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign at_org   = (h == '0) && (v == '0);
  assign line_end = (int'(h) == H_ACTIVE - 1);
  assign in_hs    = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
  assign in_vs    = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
  assign beat     = '{r: s_red_i, g: s_green_i, b: s_blue_i};

`ifdef DVI_STREAM_SYNC_PATTERN_EN
  logic [2:0] bar;

  // bar = h*8/H_ACTIVE, realised as compares against constant thresholds.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (int'(h) >= (k * H_ACTIVE + 7) / 8) bar = bar + 3'd1;
    seek_pix = '0;
    if (active)
      seek_pix = '{r: {COLOR_W{bar[2]}}, g: {COLOR_W{bar[1]}}, b: {COLOR_W{bar[0]}}};
  end
`else
  assign seek_pix = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= SEEK;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    ready   = 1'b0;
    err     = 1'b0;
    pix_d   = '0;
    case (state)
      SEEK: begin
        pix_d = seek_pix;
        ready = ~s_sof_i | at_org;
        if (s_valid_i && s_sof_i && at_org) begin
          state_d = LOCKED;
          pix_d   = beat;
        end
      end
      LOCKED: begin
        ready = active;
        if (active) begin
          if (!s_valid_i || (s_eol_i != line_end) || (s_sof_i != at_org)) begin
            err     = 1'b1;
            state_d = SEEK;
          end else begin
            pix_d = beat;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  assign s_ready_o = rst_ni & ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_o          <= 1'b0;
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      pix_q         <= '0;
      x_o           <= '0;
      y_o           <= '0;
      locked_o      <= 1'b0;
      frame_start_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      de_o          <= active;
      hsync_o       <= in_hs ? HS_POL : ~HS_POL;
      vsync_o       <= in_vs ? VS_POL : ~VS_POL;
      pix_q         <= pix_d;
      x_o           <= h;
      y_o           <= v;
      locked_o      <= (state == LOCKED);
      frame_start_o <= at_org;
      err_o         <= err;
    end
  end

  assign red_o   = pix_q.r;
  assign green_o = pix_q.g;
  assign blue_o  = pix_q.b;

endmodule

// File: tb/tb_dvi_stream_sync.sv
// Directed bench for dvi_stream_sync in an 8x6 raster (4x3 active).
module tb_dvi_stream_sync;
  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = 8, VT = 6;
`ifdef DVI_STREAM_SYNC_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       s_valid_i, s_ready_o, s_sof_i, s_eol_i;
  logic [7:0] s_red_i, s_green_i, s_blue_i;
  logic       de_o, hsync_o, vsync_o, locked_o, frame_start_o, err_o;
  logic [7:0] red_o, green_o, blue_o;
  logic [2:0] x_o, y_o;

  dvi_stream_sync #(
    .COLOR_W(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_red_i(s_red_i), .s_green_i(s_green_i),
    .s_blue_i(s_blue_i), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .x_o(x_o), .y_o(y_o),
    .locked_o(locked_o), .frame_start_o(frame_start_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int hc = 0, vc = 0, px = 0, py = 0, cyc = 0;
  int x_bad = 0, hs_bad = 0, vs_bad = 0, de_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] seek_rgb(input int x);
    logic [2:0] idx;
    idx = 3'((x * 8) / HA);
    return PAT ? {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}} : 24'h0;
  endfunction

  function automatic bit act(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic logic [23:0] idx_rgb(input int x, input int y);
    logic [7:0] d;
    d = 8'(y * HA + x);
    return {d, d, d};
  endfunction

  task automatic drive(input bit vld, input bit sof, input bit eol, input logic [23:0] d);
    s_valid_i = vld; s_sof_i = sof; s_eol_i = eol;
    {s_red_i, s_green_i, s_blue_i} = d;
  endtask

  task automatic drive_norm();
    if (act(hc, vc)) drive(1'b1, (hc == 0 && vc == 0), (hc == HA - 1), idx_rgb(hc, vc));
    else             drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // One clock; afterwards the outputs describe raster position (px,py).
  task automatic tick();
    px = hc; py = vc;
    @(posedge clk_i); #1;
    cyc++;
    if (hc == HT - 1) begin hc = 0; vc = (vc + 1) % VT; end
    else hc++;
    if (int'(x_o) != px || int'(y_o) != py) x_bad++;
    if (hsync_o !== ((px == 5 || px == 6) ? 1'b0 : 1'b1)) hs_bad++;
    if (vsync_o !== ((py == 4) ? 1'b0 : 1'b1)) vs_bad++;
    if (de_o !== act(px, py)) de_bad++;
  endtask

  initial begin
    int de_cnt, fs_a, fs_b, rgb_bad, err_cnt, rdy_cnt, n;
    logic [23:0] rgb;

    drive(1'b1, 1'b1, 1'b0, 24'h123456);
    #12;
    chk("rst_de", de_o, 0);
    chk("rst_hsync", hsync_o, 1);
    chk("rst_vsync", vsync_o, 1);
    chk("rst_xy", {x_o, y_o}, 0);
    chk("rst_rgb", {red_o, green_o, blue_o}, 0);
    chk("rst_status", {locked_o, frame_start_o, err_o}, 0);
    chk("rst_ready", s_ready_o, 0);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Free-running timing, two frames, no stream.
    de_cnt = 0; fs_a = -1; fs_b = -1; rgb_bad = 0; err_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      rgb = {red_o, green_o, blue_o};
      if (de_o) de_cnt++;
      if (frame_start_o) begin if (fs_a < 0) fs_a = cyc; else fs_b = cyc; end
      if (rgb !== (de_o ? seek_rgb(px) : 24'h0)) rgb_bad++;
      if (err_o) err_cnt++;
    end
    chk("de_count_2frames", de_cnt, 24);
    chk("fs_first", fs_a, 1);
    chk("fs_period", fs_b - fs_a, 48);
    chk("seek_rgb", rgb_bad, 0);
    chk("idle_err", err_cnt, 0);
    chk("idle_unlocked", locked_o, 0);

    // SOF beat raised mid-frame must be held until the origin.
    repeat (10) tick();
    drive(1'b1, 1'b1, 1'b0, 24'h5AC30F);
    #1;
    chk("sof_held_ready", s_ready_o, 0);
    rdy_cnt = 0; n = 0;
    while (!(hc == 0 && vc == 0) && n < 60) begin
      if (s_ready_o) rdy_cnt++;
      tick(); n++;
    end
    chk("sof_wait_bound", n < 60, 1);
    chk("sof_early_ready", rdy_cnt, 0);
    chk("sof_origin_ready", s_ready_o, 1);
    tick();
    chk("lock_pixel_rgb", {red_o, green_o, blue_o}, 24'h5AC30F);
    chk("lock_pixel_fs_de", {frame_start_o, de_o, err_o}, 3'b110);

    // Clean locked stream for the rest of this frame plus two more.
    rgb_bad = 0; err_cnt = 0; rdy_cnt = 0;
    for (int i = 0; i < 3 * HT * VT - 1; i++) begin
      drive_norm();
      if (!act(hc, vc)) begin s_valid_i = 1'b1; #1; if (s_ready_o) rdy_cnt++; s_valid_i = 1'b0; end
      tick();
      if (err_o) err_cnt++;
      if ({red_o, green_o, blue_o} !== (de_o ? idx_rgb(px, py) : 24'h0)) rgb_bad++;
    end
    chk("stream_rgb", rgb_bad, 0);
    chk("stream_err", err_cnt, 0);
    chk("stream_blank_ready", rdy_cnt, 0);
    chk("stream_locked", locked_o, 1);

    // Underflow at pixel (2,1).
    n = 0;
    while (!(hc == 2 && vc == 1) && n < 60) begin drive_norm(); tick(); n++; end
    chk("uf_seek_bound", n < 60, 1);
    drive(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
    tick();
    chk("uf_xy", {x_o, y_o}, {3'd2, 3'd1});
    chk("uf_rgb", {red_o, green_o, blue_o}, 0);
    chk("uf_err", err_o, 1);
    drive_norm();
    tick();
    chk("uf_err_once", err_o, 0);
    chk("uf_unlocked", locked_o, 0);
    chk("uf_seek_rgb", {red_o, green_o, blue_o}, seek_rgb(3));
    err_cnt = 0; n = 0;
    while (!(hc == 0 && vc == 0) && n < 60) begin
      drive_norm(); tick(); n++;
      if (err_o) err_cnt++;
    end
    chk("relock_wait_err", err_cnt, 0);
    drive(1'b1, 1'b1, 1'b0, 24'hABCDEF);
    #1;
    chk("relock_ready", s_ready_o, 1);
    tick();
    chk("relock_rgb", {red_o, green_o, blue_o}, 24'hABCDEF);
    drive_norm();
    tick();
    chk("relock_locked", locked_o, 1);
    chk("relock_next_rgb", {red_o, green_o, blue_o}, idx_rgb(1, 0));

    // Early EOL at x=2, then a non-SOF beat is swallowed in SEEK.
    drive(1'b1, 1'b0, 1'b1, idx_rgb(2, 0));
    tick();
    chk("eol_err", err_o, 1);
    chk("eol_rgb", {red_o, green_o, blue_o}, 0);
    drive(1'b1, 1'b0, 1'b0, 24'h777777);
    #1;
    chk("seek_discard_ready", s_ready_o, 1);
    tick();
    chk("seek_discard_rgb", {red_o, green_o, blue_o}, seek_rgb(3));
    chk("seek_discard_status", {locked_o, err_o}, 0);

    chk("xy_track", x_bad, 0);
    chk("hsync_track", hs_bad, 0);
    chk("vsync_track", vs_bad, 0);
    chk("de_track", de_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dvi_stream_sync.md
Name: dvi_stream_sync

Overview:
- Parametrised successor to the fixed-mode sync front-end of the DVI path.
- Generates video timing for any mode and sync polarity, and accepts pixels over a valid/ready stream with start-of-frame and end-of-line markers.
- Locks the stream to the raster and emits aligned DE/HSYNC/VSYNC/RGB, ready to feed three tmds_encoder instances.
- Detects underflow and misalignment, then re-locks automatically at the next frame.

Parameters:
- COLOR_W, 8, bits per colour component
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync_o
- VS_POL, 0, asserted level of vsync_o

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous reset, active-low
- s_valid_i  in  1  pixel beat valid
- s_ready_o  out  1  pixel beat accepted when valid and ready are both high
- s_sof_i  in  1  beat is pixel (0,0) of a frame
- s_eol_i  in  1  beat is the last pixel of a line
- s_red_i / s_green_i / s_blue_i  in  COLOR_W each  pixel data
- de_o  out  1  data enable (active video)
- hsync_o / vsync_o  out  1 each  syncs at the programmed polarity
- red_o / green_o / blue_o  out  COLOR_W each  aligned pixel data
- x_o  out  $clog2(H_TOTAL)  horizontal counter, aligned with de_o
- y_o  out  $clog2(V_TOTAL)  vertical counter, aligned with de_o
- locked_o  out  1  stream locked to raster
- frame_start_o  out  1  one-cycle pulse aligned with output (0,0)
- err_o  out  1  one-cycle pulse on underflow or misalignment

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: h increments each cycle and wraps H_TOTAL-1 -> 0; v increments on h wrap and wraps V_TOTAL-1 -> 0.
- Timing decode:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), all h.
- Latency: every output is registered, so outputs show counter state (h,v) exactly one cycle later. All outputs within a cycle are mutually aligned.
- Reset (async assert, sync release):
  - h=v=0; state SEEK.
  - de_o=0, rgb_o=0, x_o=y_o=0, locked_o=0, frame_start_o=0, err_o=0.
  - hsync_o=~HS_POL, vsync_o=~VS_POL.
  - s_ready_o is 0 while rst_ni is low.
- FSM SEEK:
  - s_ready_o = ~s_sof_i || (h==0 && v==0). Beats without SOF are discarded; a SOF beat is held until the raster reaches (0,0).
  - When a SOF beat is accepted at (0,0): go to LOCKED, and that beat is pixel (0,0).
  - RGB output is black (0).
- FSM LOCKED:
  - s_ready_o = active.
  - Every accepted beat is registered to rgb_o.
  - Go to SEEK with err_o pulse if any of:
    - s_valid_i=0 while active (underflow; that pixel is output black);
    - s_eol_i does not equal (h==H_ACTIVE-1) on an active beat;
    - s_sof_i does not equal (h==0 && v==0) on an active beat.
  - On the erroring cycle the beat is consumed but its data is replaced by black.
  - Once in SEEK, lock is reacquired at the next frame start only.
- Outputs during blanking:
  - rgb_o=0, de_o=0.
  - Input beats are never accepted in blanking while LOCKED.
- Status outputs:
  - locked_o is the registered form of (state==LOCKED).
  - frame_start_o is high when output x_o=0 and y_o=0, regardless of lock.

Optional Feature:
- Macro: DVI_STREAM_SYNC_PATTERN_EN.
- Defined: in SEEK during active video, rgb_o shows eight vertical colour bars instead of black. Bar index = x*8/H_ACTIVE (computed once as a constant stride); colour = {index[2],index[1],index[0]} mapped to all-ones or zero per channel (R=bit2, G=bit1, B=bit0).
- Not defined: SEEK outputs black. All other behaviour is identical.

Test Plan:
- Small mode H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1, no stream input:
  - H_TOTAL=8 and V_TOTAL=6; hsync_o low at x=5,6; vsync_o low for all of y=4.
  - de_o high for 12 cycles per 48-cycle frame; frame_start_o period is 48 cycles.
- Reset deasserted with s_valid_i=1 and s_sof_i=1 early: ready stays 0 until (0,0), then the beat is accepted; locked_o rises; output pixel (0,0) equals the SOF beat data one cycle later.
- Locked continuous stream of 12 beats per frame, EOL on every 4th beat, data=index: rgb_o follows the sequence 0..11 in active cycles, err_o is never pulsed, and 3 frames run clean.
- Drop s_valid_i at pixel (2,1):
  - rgb_o=0 at that pixel, err_o pulses once, locked_o falls.
  - Relock at the next (0,0) SOF beat.
- EOL asserted at x=2 (early): err_o pulses and the block enters SEEK. Non-SOF beats are then consumed with ready=1 and discarded.
- With DVI_STREAM_SYNC_PATTERN_EN and H_ACTIVE=640, unlocked: x=0..79 gives 0/0/0; x=80 gives B=255 only; x=560..639 gives 255/255/255.
